// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared widths and FSM state type for the pipeline control slice
package pipeline_ctrl_pkg;
  localparam int DATA_WID = 32;
  localparam int REG_WID = 5;
  localparam int CNT_WID = 32;
  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_WAIT_PF} state_t;
  function automatic logic [CNT_WID-1:0] sat_inc(input logic [CNT_WID-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: flags a load in EX whose destination feeds a valid ID source (ex_* load info, id_* sources -> load_use)
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic               ex_mem_read,
  input  logic [REG_WID-1:0] ex_rd,
  input  logic [REG_WID-1:0] id_rs1,
  input  logic [REG_WID-1:0] id_rs2,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  output logic               load_use
);
  assign load_use = ex_mem_read && ex_rd != '0 &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush control (cache stalls, mispredict flush, load-use bubble) with stall_cycles and flush_count counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               icache_stall,
  input  logic               dcache_stall,
  input  logic               predict_fail,
  input  logic               ex_mem_read,
  input  logic [REG_WID-1:0] ex_rd,
  input  logic [REG_WID-1:0] id_rs1,
  input  logic [REG_WID-1:0] id_rs2,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  output logic               pc_hold,
  output logic               if_id_hold,
  output logic               if_id_flush,
  output logic               id_ex_hold,
  output logic               id_ex_flush,
  output logic               ex_mem_hold,
  output logic               mem_wb_hold,
  output logic [CNT_WID-1:0] stall_cycles,
  output logic [CNT_WID-1:0] flush_count
);
  state_t state;
  logic load_use, flush_ev, dc, fl, lu, ic;
  hazard_detect u_hazard (
    .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .load_use(load_use)
  );
  // one-hot event selection in priority order dcache > flush > load-use > icache
  always_comb begin
    flush_ev = predict_fail || state == MEM_WAIT_PF;
    dc = !rst && dcache_stall;
    fl = !rst && !dcache_stall && flush_ev;
    lu = !rst && !dcache_stall && !flush_ev && load_use;
    ic = !rst && !dcache_stall && !flush_ev && !load_use && icache_stall;
    pc_hold = dc || lu || ic;
    if_id_hold = dc || lu;
    if_id_flush = fl || ic;
    id_ex_hold = dc;
    id_ex_flush = fl || lu;
    ex_mem_hold = dc;
    mem_wb_hold = dc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      state <= dcache_stall ? (flush_ev ? MEM_WAIT_PF : MEM_WAIT) : RUN;
      if (pc_hold) stall_cycles <= sat_inc(stall_cycles);
      if (fl) flush_count <= sat_inc(flush_count);
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed stimulus checked every cycle against a behavioural model of pipeline_ctrl
module tb_pipeline_ctrl;
  logic clk = 0, rst = 1;
  logic icache_stall = 0, dcache_stall = 0, predict_fail = 0, ex_mem_read = 0;
  logic [4:0] ex_rd = 0, id_rs1 = 0, id_rs2 = 0;
  logic id_use_rs1 = 0, id_use_rs2 = 0;
  logic pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_hold;
  logic [31:0] stall_cycles, flush_count;
  logic [6:0] ctrl;
  int checks = 0, errors = 0;
  bit m_pending = 0;
  longint m_stall = 0, m_flush = 0;
  localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;
  pipeline_ctrl dut (
    .clk(clk), .rst(rst), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .predict_fail(predict_fail), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush), .ex_mem_hold(ex_mem_hold),
    .mem_wb_hold(mem_wb_hold), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  assign ctrl = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_hold};
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  // control bit order: pc, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_hold
  function automatic logic [6:0] model_ctrl();
    bit hazard;
    hazard = ex_mem_read && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (rst) return 7'b0000000;
    if (dcache_stall) return 7'b1101011;
    if (predict_fail || m_pending) return 7'b0010100;
    if (hazard) return 7'b1100100;
    if (icache_stall) return 7'b1010000;
    return 7'b0000000;
  endfunction
  task automatic tick();
    logic [6:0] e;
    @(negedge clk);
    e = model_ctrl();
    chk("ctrl", {25'd0, ctrl}, {25'd0, e});
    chk("stall_cycles", stall_cycles, m_stall[31:0]);
    chk("flush_count", flush_count, m_flush[31:0]);
    chk("no_hold_and_flush", {30'd0, if_id_hold & if_id_flush, id_ex_hold & id_ex_flush}, 32'd0);
    @(posedge clk);
    if (rst) begin
      m_pending = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (e[6]) m_stall = (m_stall + 1 > MAXC) ? MAXC : m_stall + 1;
      if (e == 7'b0010100) m_flush = (m_flush + 1 > MAXC) ? MAXC : m_flush + 1;
      m_pending = dcache_stall && (m_pending || predict_fail);
    end
    #1;
  endtask
  task automatic idle();
    {icache_stall, dcache_stall, predict_fail, ex_mem_read, id_use_rs1, id_use_rs2} = '0;
    ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
  endtask
  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
    ex_mem_read = 1; ex_rd = rd; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
  endtask
  initial begin
    @(posedge clk); #1;
    dcache_stall = 1; icache_stall = 1; predict_fail = 1;
    #1 chk("reset_ctrl_zero", {25'd0, ctrl}, 32'd0);
    tick();
    chk("reset_counters", stall_cycles | flush_count, 32'd0);
    idle(); rst = 0;
    tick();
    load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    #1 chk("load_use_pin", {25'd0, ctrl}, 32'b1100100);
    tick();
    chk("load_use_stall_pin", stall_cycles, 32'd1);
    idle(); tick();
    load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1 chk("rd_zero_pin", {25'd0, ctrl}, 32'd0);
    tick();
    load_use(5'd9, 5'd3, 1'b1, 5'd9, 1'b1); tick();
    load_use(5'd9, 5'd3, 1'b1, 5'd9, 1'b0); tick();
    load_use(5'd9, 5'd9, 1'b0, 5'd9, 1'b0); tick();
    ex_mem_read = 0; id_use_rs1 = 1; tick();
    idle();
    dcache_stall = 1; predict_fail = 1;
    #1 chk("dcache_pin", {25'd0, ctrl}, 32'b1101011);
    tick();
    predict_fail = 0; tick(); tick();
    dcache_stall = 0;
    #1 chk("pending_flush_pin", {25'd0, ctrl}, 32'b0010100);
    tick();
    chk("flush_once_pin", {25'd0, ctrl}, 32'd0);
    tick();
    chk("flush_count_pin", flush_count, 32'd1);
    chk("stall_after_dcache_pin", stall_cycles, 32'd5);
    icache_stall = 1; load_use(5'd7, 5'd1, 1'b0, 5'd7, 1'b1);
    #1 chk("lu_over_icache_pin", {25'd0, ctrl}, 32'b1100100);
    tick();
    ex_mem_read = 0;
    #1 chk("icache_pin", {25'd0, ctrl}, 32'b1010000);
    tick();
    idle(); icache_stall = 1; predict_fail = 1; tick();
    idle(); tick();
    dcache_stall = 1; predict_fail = 1; tick();
    predict_fail = 0; rst = 1; tick();
    rst = 0; dcache_stall = 0;
    #1 chk("no_flush_after_rst_pin", {25'd0, ctrl}, 32'd0);
    chk("rst_counters_pin", stall_cycles | flush_count, 32'd0);
    tick(); tick();
    force dut.stall_cycles = 32'hFFFF_FFFC;
    #1 release dut.stall_cycles;
    m_stall = 64'h0000_0000_FFFF_FFFC;
    icache_stall = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_saturate_pin", stall_cycles, 32'hFFFF_FFFF);
    idle(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  clock; all state updates on the rising edge.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: icache_stall  input  1  instruction fetch not ready this cycle.
REQ-004 SHALL have ports: dcache_stall  input  1  data access not ready this cycle.
REQ-005 SHALL have ports: predict_fail  input  1  EX-stage branch misprediction, one-cycle pulse.
REQ-006 SHALL have ports: ex_mem_read  input  1  instruction in EX is a load.
REQ-007 SHALL have ports: ex_rd  input  5  load destination register; id_rs1, id_rs2  input  5 each  ID source registers; id_use_rs1, id_use_rs2  input  1 each  source valid.
REQ-008 SHALL have ports: pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_hold  output  1 each  stage controls sampled by stage registers at the next edge.
REQ-009 SHALL have ports: stall_cycles  output  32  count of cycles with pc_hold=1; flush_count  output  32  count of issued mispredict flushes.

Function
REQ-010 SHALL implement FSM states RUN, MEM_WAIT and MEM_WAIT_PF (MEM_WAIT with a mispredict flush pending).
REQ-011 Control outputs SHALL be combinational from state and current inputs, with priority dcache > flush > load-use > icache.
REQ-012 With dcache_stall=1, SHALL assert pc_hold, if_id_hold, id_ex_hold, ex_mem_hold and mem_wb_hold, and deassert both flushes.
REQ-013 With dcache_stall=1, SHALL go to MEM_WAIT, or to MEM_WAIT_PF if predict_fail=1 or the state is already MEM_WAIT_PF.
REQ-014 With dcache_stall=0 and (predict_fail=1 or state=MEM_WAIT_PF), SHALL assert if_id_flush and id_ex_flush, keep all holds 0, increment flush_count once and go to RUN.
REQ-015 A load-use hazard SHALL be defined as ex_mem_read=1, ex_rd!=0, and (id_use_rs1 with id_rs1==ex_rd, or id_use_rs2 with id_rs2==ex_rd).
REQ-016 A load-use hazard with no higher-priority event SHALL assert pc_hold, if_id_hold and id_ex_flush (one bubble); all other outputs SHALL be 0.
REQ-017 icache_stall=1 with no higher-priority event SHALL assert pc_hold and if_id_flush (fetch bubble); all other outputs SHALL be 0.
REQ-018 When no event is present, SHALL drive all controls to 0 and go to RUN.
REQ-019 Flush and hold of the same stage SHALL never both be 1 in the same cycle.
REQ-020 stall_cycles SHALL increment on every cycle with pc_hold=1, saturating at 0xFFFF_FFFF; flush_count SHALL saturate at the same value.
REQ-021 A pending flush SHALL survive any length of dcache stall and SHALL be issued exactly once, in the first cycle with dcache_stall=0.

Reset
REQ-022 With rst=1 at a clock edge, SHALL set state to RUN and zero both counters, which discards any pending flush.
REQ-023 While rst=1, SHALL drive all control outputs to 0, regardless of other inputs.
REQ-024 SHALL assign rst priority over every input, including mid-stall and pending-flush states.

Structure
REQ-025 The FSM state enum and the REG_WID=5 and CNT_WID=32 constants SHALL reside in the shared package next to DATA_WID.
REQ-026 Hazard comparison SHALL be a sub-module hazard_detect; counters SHALL be inline in pipeline_ctrl.

Verification
REQ-027 ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_hold=1, if_id_hold=1, id_ex_flush=1 for one cycle; stall_cycles +1.
REQ-028 Same as REQ-027 but ex_rd=0 -> all controls 0.
REQ-029 dcache_stall=1 for 3 cycles with predict_fail pulsed in cycle 1 -> holds asserted for 3 cycles; flushes issued in cycle 4 only; flush_count=1.
REQ-030 icache_stall and load-use hazard in the same cycle -> load-use response per REQ-016; next cycle with icache only -> pc_hold=1, if_id_flush=1.
REQ-031 rst pulsed in state MEM_WAIT_PF -> no flush after release; counters 0.
REQ-032 stall_cycles preset near 0xFFFF_FFFF, then 5 stall cycles -> value holds at 0xFFFF_FFFF.
